// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the fetch stage.
//
// Holds the fetch PC and selects the next one each cycle. Redirects take
// priority over stall, highest first: trap entry, trap return, taken branch.
// A taken branch to a misaligned target is turned into a trap entry.
// Otherwise the PC holds on stall, or advances by 4 and wraps at 2^XLEN.
//
// Ports:
//   clk           in   rising-edge clock
//   rst           in   synchronous active-high reset
//   stall         in   hold PC
//   branch_taken  in   redirect to branch_target
//   branch_target in   [XLEN] branch/jump target
//   trap          in   exception/interrupt entry request
//   trap_ret      in   return-from-trap request
//   pc            out  [XLEN] current fetch address
//   pc_plus4      out  [XLEN] pc + 4, combinational
//   epc           out  [XLEN] saved exception PC
//   misaligned    out  one-cycle pulse after a misaligned taken branch
//   flush         out  one-cycle pulse after any redirect
module pc_gen #(
    parameter int unsigned           XLEN         = 32,
    parameter logic [XLEN-1:0]       RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]       TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            trap,
    input  logic            trap_ret,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] epc,
    output logic            misaligned,
    output logic            flush
);

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_TRAP,
        SEL_TRET,
        SEL_BRANCH,
        SEL_MISALIGN
    } sel_e;

    sel_e            sel;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            misaligned_q, misaligned_d;
    logic            flush_q, flush_d;
    logic [XLEN-1:0] pc_inc;

    // Natural XLEN-bit addition drops the carry, giving the modulo wrap.
    assign pc_inc = pc_q + XLEN'(4);

    // Priority select of the next-PC source.
    always_comb begin
        sel = SEL_SEQ;
        if (trap) begin
            sel = SEL_TRAP;
        end else if (trap_ret) begin
            sel = SEL_TRET;
        end else if (branch_taken) begin
            sel = (branch_target[1:0] == 2'b00) ? SEL_BRANCH : SEL_MISALIGN;
        end else if (stall) begin
            sel = SEL_HOLD;
        end
    end

    always_comb begin
        pc_d         = pc_inc;
        epc_d        = epc_q;
        misaligned_d = 1'b0;
        flush_d      = 1'b0;
        unique case (sel)
            SEL_TRAP: begin
                pc_d    = TRAP_VECTOR;
                epc_d   = pc_q;
                flush_d = 1'b1;
            end
            SEL_TRET: begin
                pc_d    = epc_q;
                flush_d = 1'b1;
            end
            SEL_BRANCH: begin
                pc_d    = branch_target;
                flush_d = 1'b1;
            end
            // Misaligned target behaves as an internal trap; target dropped.
            SEL_MISALIGN: begin
                pc_d         = TRAP_VECTOR;
                epc_d        = pc_q;
                misaligned_d = 1'b1;
                flush_d      = 1'b1;
            end
            SEL_HOLD: begin
                pc_d = pc_q;
            end
            default: begin
                pc_d = pc_inc;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q         <= RESET_VECTOR;
            epc_q        <= '0;
            misaligned_q <= 1'b0;
            flush_q      <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            epc_q        <= epc_d;
            misaligned_q <= misaligned_d;
            flush_q      <= flush_d;
        end
    end

    assign pc         = pc_q;
    assign pc_plus4   = pc_inc;
    assign epc        = epc_q;
    assign misaligned = misaligned_q;
    assign flush      = flush_q;

endmodule
